pipeline_exec_controller: RTL and testbench
===========================================

Name: pipeline_exec_controller

Overview:
- Sequences the 5-stage pipeline: gates PC write, IF/ID write, IF flush and ID/EX bubble insertion, and holds a global pipeline enable.
- Sits between the debug unit (run/step/stop commands), the hazard/branch logic in ID, and the IF stage (PC register, IF/ID latch).
- Handles continuous run, single-step, load-use stalls, branch flushes, and HALT drain, and keeps a cycle counter for the debug unit.

Parameters:
- PC_WIDTH, 9, width of the PC compared against the breakpoint (optional feature).
- CNT_WIDTH, 32, cycle counter width.
- DRAIN_CYCLES, 4, cycles the pipeline keeps running after HALT is fetched, so in-flight instructions retire.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command strobe from debug unit.
- i_cmd  in  2  command code: 01 = RUN, 10 = STEP, 11 = STOP, 00 = NOP.
- o_cmd_ready  out  1  high when the controller accepts a command this cycle.
- i_halt_fetched  in  1  IF stage decoded a HALT opcode this cycle.
- i_load_use_hazard  in  1  load-use hazard detected in ID.
- i_branch_taken  in  1  branch/jump resolved taken in ID.
- i_PC  in  PC_WIDTH  current IF-stage PC (used only with the optional feature).
- o_pipe_enable  out  1  global enable for all pipeline latches and the PC.
- o_PCwrite  out  1  PC register write enable.
- o_IF_ID_write  out  1  IF/ID latch write enable.
- o_IF_flush  out  1  clear IF/ID latch.
- o_ID_EX_bubble  out  1  zero the ID/EX control signals.
- o_halted  out  1  program finished (HALTED state).
- o_cycle_count  out  CNT_WIDTH  number of enabled cycles.

Behaviour:
- Reset: state IDLE, drain counter 0, o_cycle_count 0, o_halted 0. All enables/flush/bubble outputs are 0 while in IDLE.
- States: IDLE, RUN, STEP, DRAIN, HALTED.
- o_cmd_ready is 1 in IDLE and RUN, 0 in STEP and DRAIN, and 1 in HALTED (only STOP is acted on there).
- A command is accepted on the cycle where i_cmd_valid and o_cmd_ready are both 1.
- IDLE:
  - RUN goes to RUN.
  - STEP goes to STEP.
  - STOP and NOP are ignored.
- RUN:
  - o_pipe_enable = 1.
  - STOP goes to IDLE next cycle; the accepting cycle is still enabled.
  - RUN and STEP are ignored.
- STEP:
  - o_pipe_enable = 1 for exactly one cycle, then IDLE.
- HALT entry:
  - In RUN or STEP, i_halt_fetched = 1 forces o_PCwrite = 0 and o_IF_ID_write = 0 that cycle.
  - Drain counter loads DRAIN_CYCLES and the state goes to DRAIN.
  - HALT takes priority over STOP and over the STEP return to IDLE.
- DRAIN:
  - o_pipe_enable = 1, o_PCwrite = 0, o_IF_flush = 1 (HALT and anything behind it never enter ID).
  - Counter decrements each cycle; at 1 the state goes to HALTED.
- HALTED:
  - All enables 0, o_halted = 1.
  - An accepted STOP returns to IDLE with o_halted = 0 and o_cycle_count = 0; RUN and STEP are ignored.
- Enable gating in RUN/STEP with no HALT: o_PCwrite = o_IF_ID_write = 1 unless a stall applies.
- Load-use stall (combinational, only while o_pipe_enable = 1):
  - o_PCwrite = 0, o_IF_ID_write = 0, o_ID_EX_bubble = 1.
  - Takes priority over i_branch_taken: o_IF_flush = 0 that cycle, and the branch re-resolves after the stall.
- Branch taken without a stall: o_IF_flush = 1 and o_PCwrite = 1 (branch target loaded through the PC mux).
- A STEP cycle that hits a stall still consumes the step; the stall repeats on the next STEP.
- Cycle counter: increments on every cycle with o_pipe_enable = 1 and saturates at all-ones.
- Reset asserted in any state, including mid-DRAIN, returns to the reset values on the next edge.

Optional Feature:
- Macro: PIPE_CTRL_BREAKPOINT_EN.
- When defined, adds these ports:
  - i_bp_set  in  1  load the breakpoint.
  - i_bp_addr  in  PC_WIDTH  breakpoint address.
  - o_bp_hit  out  1  breakpoint hit pulse.
- i_bp_set loads an internal breakpoint register and sets its valid bit; reset clears the valid bit.
- In RUN, when i_PC equals the breakpoint and valid = 1:
  - o_PCwrite = 0 and o_IF_ID_write = 0 that cycle.
  - State goes to IDLE and o_bp_hit pulses high for one cycle.
- A later RUN resumes from the same PC. The breakpoint is ignored in the first cycle after leaving IDLE, so RUN can move past it.
- When undefined: none of these ports exist, and no compare logic is built.

Test Plan:
- Reset then RUN at cycle 2 → o_pipe_enable = 1 from cycle 3, o_PCwrite = 1; o_cycle_count = 10 after 10 enabled cycles; STOP → IDLE, count holds at 10.
- STEP ×3 from IDLE → exactly 3 single-cycle o_pipe_enable pulses; o_cmd_ready = 0 during each STEP cycle; o_cycle_count = 3.
- RUN with i_load_use_hazard = 1 and i_branch_taken = 1 in the same cycle → o_PCwrite = 0, o_IF_ID_write = 0, o_ID_EX_bubble = 1, o_IF_flush = 0; next cycle branch only → o_IF_flush = 1, o_PCwrite = 1.
- RUN, pulse i_halt_fetched → that cycle o_PCwrite = 0; 4 DRAIN cycles with o_IF_flush = 1, then o_halted = 1 and all enables 0; RUN ignored; STOP → IDLE, o_cycle_count = 0.
- Reset asserted at the 2nd DRAIN cycle → next cycle IDLE, o_halted = 0, o_cycle_count = 0, all outputs 0.
- With PIPE_CTRL_BREAKPOINT_EN: bp = 0x010, RUN from PC 0 → stop with o_bp_hit pulse at PC 0x010, o_PCwrite = 0; RUN again → PC advances past 0x010.

Source files
------------

// File: rtl/pipeline_exec_controller_if.sv
// pipeline_exec_controller_if: debug command, hazard and pipeline-gating signals of the execution controller
//   slave  (controller): takes i_cmd_valid/i_cmd, i_halt_fetched, i_load_use_hazard, i_branch_taken, i_PC
//                        and drives o_cmd_ready, o_pipe_enable, o_PCwrite, o_IF_ID_write, o_IF_flush,
//                        o_ID_EX_bubble, o_halted, o_cycle_count
//   master (debug unit / pipeline side): the opposite directions
//   PIPE_CTRL_BREAKPOINT_EN adds i_bp_set, i_bp_addr, o_bp_hit
interface pipeline_exec_controller_if #(
    parameter int PC_WIDTH  = 9,
    parameter int CNT_WIDTH = 32
);
    logic                 i_cmd_valid;
    logic [1:0]           i_cmd;
    logic                 o_cmd_ready;
    logic                 i_halt_fetched;
    logic                 i_load_use_hazard;
    logic                 i_branch_taken;
    logic [PC_WIDTH-1:0]  i_PC;
    logic                 o_pipe_enable;
    logic                 o_PCwrite;
    logic                 o_IF_ID_write;
    logic                 o_IF_flush;
    logic                 o_ID_EX_bubble;
    logic                 o_halted;
    logic [CNT_WIDTH-1:0] o_cycle_count;
`ifdef PIPE_CTRL_BREAKPOINT_EN
    logic                 i_bp_set;
    logic [PC_WIDTH-1:0]  i_bp_addr;
    logic                 o_bp_hit;
`endif
    modport master (
`ifdef PIPE_CTRL_BREAKPOINT_EN
        output i_bp_set, i_bp_addr,
        input  o_bp_hit,
`endif
        output i_cmd_valid, i_cmd, i_halt_fetched, i_load_use_hazard, i_branch_taken, i_PC,
        input  o_cmd_ready, o_pipe_enable, o_PCwrite, o_IF_ID_write, o_IF_flush, o_ID_EX_bubble,
               o_halted, o_cycle_count
    );
    modport slave (
`ifdef PIPE_CTRL_BREAKPOINT_EN
        input  i_bp_set, i_bp_addr,
        output o_bp_hit,
`endif
        input  i_cmd_valid, i_cmd, i_halt_fetched, i_load_use_hazard, i_branch_taken, i_PC,
        output o_cmd_ready, o_pipe_enable, o_PCwrite, o_IF_ID_write, o_IF_flush, o_ID_EX_bubble,
               o_halted, o_cycle_count
    );
endinterface

// File: rtl/pipeline_exec_controller.sv
// pipeline_exec_controller: run/step/stop sequencing, stall/flush gating and HALT drain for a 5-stage pipeline
//   i_clk, i_reset : clock and synchronous active-high reset
//   bus (slave)    : debug commands in, hazard/branch/HALT status in, pipeline enables and cycle count out
//   PIPE_CTRL_BREAKPOINT_EN : when defined, adds a PC breakpoint that stops RUN and pulses o_bp_hit
module pipeline_exec_controller #(
    parameter int PC_WIDTH     = 9,
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input logic                        i_clk,
    input logic                        i_reset,
    pipeline_exec_controller_if.slave  bus
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [1:0] CMD_RUN = 2'b01, CMD_STEP = 2'b10, CMD_STOP = 2'b11;
    typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;
    state_t               state_q;
    logic [DW-1:0]        drain_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic active, pipe_en, cmd_ready, accept, is_run, is_step, is_stop, halt_entry, stall, bp_hit;
    assign active     = state_q == RUN || state_q == STEP;
    assign pipe_en    = active || state_q == DRAIN;
    assign cmd_ready  = state_q == IDLE || state_q == RUN || state_q == HALTED;
    assign accept     = bus.i_cmd_valid && cmd_ready;
    assign is_run     = accept && bus.i_cmd == CMD_RUN;
    assign is_step    = accept && bus.i_cmd == CMD_STEP;
    assign is_stop    = accept && bus.i_cmd == CMD_STOP;
    assign halt_entry = active && bus.i_halt_fetched;
    assign stall      = pipe_en && bus.i_load_use_hazard;
    assign cnt_d      = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
`ifdef PIPE_CTRL_BREAKPOINT_EN
    logic [PC_WIDTH-1:0] bp_addr_q;
    logic                bp_valid_q, was_idle_q;
    // was_idle_q masks the compare in the first RUN cycle so a resumed RUN can step off the breakpoint PC
    assign bp_hit = state_q == RUN && bp_valid_q && !was_idle_q && !halt_entry && bus.i_PC == bp_addr_q;
    assign bus.o_bp_hit = bp_hit;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bp_valid_q <= 1'b0;
            was_idle_q <= 1'b1;
        end else begin
            if (bus.i_bp_set) begin
                bp_addr_q  <= bus.i_bp_addr;
                bp_valid_q <= 1'b1;
            end
            was_idle_q <= state_q == IDLE;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.i_PC;
    assign bp_hit    = 1'b0;
`endif
    assign bus.o_cmd_ready    = cmd_ready;
    assign bus.o_pipe_enable  = pipe_en;
    assign bus.o_PCwrite      = active && !halt_entry && !stall && !bp_hit;
    assign bus.o_IF_ID_write  = active && !halt_entry && !stall && !bp_hit;
    // during DRAIN the flush keeps HALT and everything fetched after it out of ID
    assign bus.o_IF_flush     = state_q == DRAIN || (active && !stall && bus.i_branch_taken);
    assign bus.o_ID_EX_bubble = stall;
    assign bus.o_halted       = state_q == HALTED;
    assign bus.o_cycle_count  = cnt_q;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (pipe_en) cnt_q <= cnt_d;
            case (state_q)
                IDLE: state_q <= is_run ? RUN : is_step ? STEP : IDLE;
                RUN, STEP: begin
                    if (halt_entry) begin
                        state_q <= DRAIN;
                        drain_q <= DW'(DRAIN_CYCLES);
                    end else if (state_q == STEP || is_stop || bp_hit) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q - DW'(1);
                    if (drain_q <= DW'(1)) state_q <= HALTED;
                end
                HALTED: begin
                    if (is_stop) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_exec_controller.sv
// tb_pipeline_exec_controller: directed checks of run/step/stop, stalls, branch flush, HALT drain and reset
module tb_pipeline_exec_controller;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    pipeline_exec_controller_if #(.PC_WIDTH(9), .CNT_WIDTH(32)) bus ();
    pipeline_exec_controller #(.PC_WIDTH(9), .CNT_WIDTH(32), .DRAIN_CYCLES(4)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );
    task automatic do_reset;
        rst = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd = 2'b00;
        bus.i_halt_fetched = 1'b0;
        bus.i_load_use_hazard = 1'b0;
        bus.i_branch_taken = 1'b0;
        bus.i_PC = '0;
`ifdef PIPE_CTRL_BREAKPOINT_EN
        bus.i_bp_set = 1'b0;
        bus.i_bp_addr = '0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic cmd(input logic [1:0] c);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd = c;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd = 2'b00;
    endtask
    task automatic test_reset;
        do_reset;
        #1;
        checks++; if (bus.o_pipe_enable !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", bus.o_pipe_enable); end
        checks++; if (bus.o_PCwrite !== 1'b0) begin failures++; $display("FAIL reset_pcw got=%b exp=0", bus.o_PCwrite); end
        checks++; if (bus.o_IF_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", bus.o_IF_flush); end
        checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.o_halted); end
        checks++; if (bus.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_cmd_ready); end
        checks++; if (bus.o_cycle_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.o_cycle_count); end
    endtask
    task automatic test_run;
        do_reset;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd = 2'b01;
        #1;
        checks++; if (bus.o_pipe_enable !== 1'b0) begin failures++; $display("FAIL run_idle_en got=%b exp=0", bus.o_pipe_enable); end
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        #1;
        checks++; if (bus.o_pipe_enable !== 1'b1) begin failures++; $display("FAIL run_en got=%b exp=1", bus.o_pipe_enable); end
        checks++; if (bus.o_PCwrite !== 1'b1) begin failures++; $display("FAIL run_pcw got=%b exp=1", bus.o_PCwrite); end
        checks++; if (bus.o_IF_ID_write !== 1'b1) begin failures++; $display("FAIL run_ifid got=%b exp=1", bus.o_IF_ID_write); end
        checks++; if (bus.o_cycle_count !== 32'd0) begin failures++; $display("FAIL run_count0 got=%0d exp=0", bus.o_cycle_count); end
        repeat (9) @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd = 2'b11;
        #1;
        checks++; if (bus.o_pipe_enable !== 1'b1) begin failures++; $display("FAIL stop_cycle_en got=%b exp=1", bus.o_pipe_enable); end
        checks++; if (bus.o_cycle_count !== 32'd9) begin failures++; $display("FAIL run_count9 got=%0d exp=9", bus.o_cycle_count); end
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        #1;
        checks++; if (bus.o_pipe_enable !== 1'b0) begin failures++; $display("FAIL stop_en got=%b exp=0", bus.o_pipe_enable); end
        checks++; if (bus.o_cycle_count !== 32'd10) begin failures++; $display("FAIL run_count10 got=%0d exp=10", bus.o_cycle_count); end
        @(negedge clk);
        #1;
        checks++; if (bus.o_cycle_count !== 32'd10) begin failures++; $display("FAIL idle_hold got=%0d exp=10", bus.o_cycle_count); end
    endtask
    task automatic test_step;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            cmd(2'b10);
            #1;
            checks++; if (bus.o_pipe_enable !== 1'b1) begin failures++; $display("FAIL step%0d_en got=%b exp=1", i, bus.o_pipe_enable); end
            checks++; if (bus.o_cmd_ready !== 1'b0) begin failures++; $display("FAIL step%0d_ready got=%b exp=0", i, bus.o_cmd_ready); end
            @(negedge clk);
            #1;
            checks++; if (bus.o_pipe_enable !== 1'b0) begin failures++; $display("FAIL step%0d_after got=%b exp=0", i, bus.o_pipe_enable); end
        end
        checks++; if (bus.o_cycle_count !== 32'd3) begin failures++; $display("FAIL step_count got=%0d exp=3", bus.o_cycle_count); end
    endtask
    task automatic test_stall_branch;
        do_reset;
        cmd(2'b01);
        bus.i_load_use_hazard = 1'b1;
        bus.i_branch_taken = 1'b1;
        #1;
        checks++; if (bus.o_PCwrite !== 1'b0) begin failures++; $display("FAIL stall_pcw got=%b exp=0", bus.o_PCwrite); end
        checks++; if (bus.o_IF_ID_write !== 1'b0) begin failures++; $display("FAIL stall_ifid got=%b exp=0", bus.o_IF_ID_write); end
        checks++; if (bus.o_ID_EX_bubble !== 1'b1) begin failures++; $display("FAIL stall_bubble got=%b exp=1", bus.o_ID_EX_bubble); end
        checks++; if (bus.o_IF_flush !== 1'b0) begin failures++; $display("FAIL stall_flush got=%b exp=0", bus.o_IF_flush); end
        @(negedge clk);
        bus.i_load_use_hazard = 1'b0;
        #1;
        checks++; if (bus.o_IF_flush !== 1'b1) begin failures++; $display("FAIL branch_flush got=%b exp=1", bus.o_IF_flush); end
        checks++; if (bus.o_PCwrite !== 1'b1) begin failures++; $display("FAIL branch_pcw got=%b exp=1", bus.o_PCwrite); end
        checks++; if (bus.o_ID_EX_bubble !== 1'b0) begin failures++; $display("FAIL branch_bubble got=%b exp=0", bus.o_ID_EX_bubble); end
        @(negedge clk);
        bus.i_branch_taken = 1'b0;
        #1;
        checks++; if (bus.o_IF_flush !== 1'b0) begin failures++; $display("FAIL plain_flush got=%b exp=0", bus.o_IF_flush); end
    endtask
    task automatic test_halt;
        do_reset;
        cmd(2'b01);
        bus.i_halt_fetched = 1'b1;
        #1;
        checks++; if (bus.o_PCwrite !== 1'b0) begin failures++; $display("FAIL halt_pcw got=%b exp=0", bus.o_PCwrite); end
        checks++; if (bus.o_IF_ID_write !== 1'b0) begin failures++; $display("FAIL halt_ifid got=%b exp=0", bus.o_IF_ID_write); end
        checks++; if (bus.o_pipe_enable !== 1'b1) begin failures++; $display("FAIL halt_en got=%b exp=1", bus.o_pipe_enable); end
        @(negedge clk);
        bus.i_halt_fetched = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.o_pipe_enable !== 1'b1) begin failures++; $display("FAIL drain%0d_en got=%b exp=1", i, bus.o_pipe_enable); end
            checks++; if (bus.o_IF_flush !== 1'b1) begin failures++; $display("FAIL drain%0d_flush got=%b exp=1", i, bus.o_IF_flush); end
            checks++; if (bus.o_PCwrite !== 1'b0) begin failures++; $display("FAIL drain%0d_pcw got=%b exp=0", i, bus.o_PCwrite); end
            checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL drain%0d_halted got=%b exp=0", i, bus.o_halted); end
            checks++; if (bus.o_cmd_ready !== 1'b0) begin failures++; $display("FAIL drain%0d_ready got=%b exp=0", i, bus.o_cmd_ready); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.o_halted !== 1'b1) begin failures++; $display("FAIL halted got=%b exp=1", bus.o_halted); end
        checks++; if (bus.o_pipe_enable !== 1'b0) begin failures++; $display("FAIL halted_en got=%b exp=0", bus.o_pipe_enable); end
        checks++; if (bus.o_IF_flush !== 1'b0) begin failures++; $display("FAIL halted_flush got=%b exp=0", bus.o_IF_flush); end
        checks++; if (bus.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL halted_ready got=%b exp=1", bus.o_cmd_ready); end
        checks++; if (bus.o_cycle_count !== 32'd5) begin failures++; $display("FAIL halted_count got=%0d exp=5", bus.o_cycle_count); end
        cmd(2'b01);
        #1;
        checks++; if (bus.o_halted !== 1'b1) begin failures++; $display("FAIL halted_run got=%b exp=1", bus.o_halted); end
        checks++; if (bus.o_pipe_enable !== 1'b0) begin failures++; $display("FAIL halted_run_en got=%b exp=0", bus.o_pipe_enable); end
        cmd(2'b11);
        #1;
        checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL halted_stop got=%b exp=0", bus.o_halted); end
        checks++; if (bus.o_cycle_count !== 32'd0) begin failures++; $display("FAIL halted_stop_count got=%0d exp=0", bus.o_cycle_count); end
        checks++; if (bus.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL halted_stop_ready got=%b exp=1", bus.o_cmd_ready); end
    endtask
    task automatic test_reset_drain;
        do_reset;
        cmd(2'b01);
        bus.i_halt_fetched = 1'b1;
        @(negedge clk);
        bus.i_halt_fetched = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.o_IF_flush !== 1'b1) begin failures++; $display("FAIL rdrain_flush got=%b exp=1", bus.o_IF_flush); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.o_pipe_enable !== 1'b0) begin failures++; $display("FAIL rdrain_en got=%b exp=0", bus.o_pipe_enable); end
        checks++; if (bus.o_IF_flush !== 1'b0) begin failures++; $display("FAIL rdrain_flush2 got=%b exp=0", bus.o_IF_flush); end
        checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL rdrain_halted got=%b exp=0", bus.o_halted); end
        checks++; if (bus.o_cycle_count !== 32'd0) begin failures++; $display("FAIL rdrain_count got=%0d exp=0", bus.o_cycle_count); end
        checks++; if (bus.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL rdrain_ready got=%b exp=1", bus.o_cmd_ready); end
    endtask
    task automatic test_step_corner;
        do_reset;
        cmd(2'b10);
        bus.i_load_use_hazard = 1'b1;
        #1;
        checks++; if (bus.o_ID_EX_bubble !== 1'b1) begin failures++; $display("FAIL sstall_bubble got=%b exp=1", bus.o_ID_EX_bubble); end
        checks++; if (bus.o_PCwrite !== 1'b0) begin failures++; $display("FAIL sstall_pcw got=%b exp=0", bus.o_PCwrite); end
        @(negedge clk);
        bus.i_load_use_hazard = 1'b0;
        #1;
        checks++; if (bus.o_pipe_enable !== 1'b0) begin failures++; $display("FAIL sstall_idle got=%b exp=0", bus.o_pipe_enable); end
        cmd(2'b10);
        bus.i_halt_fetched = 1'b1;
        #1;
        checks++; if (bus.o_PCwrite !== 1'b0) begin failures++; $display("FAIL shalt_pcw got=%b exp=0", bus.o_PCwrite); end
        @(negedge clk);
        bus.i_halt_fetched = 1'b0;
        #1;
        checks++; if (bus.o_pipe_enable !== 1'b1) begin failures++; $display("FAIL shalt_drain_en got=%b exp=1", bus.o_pipe_enable); end
        checks++; if (bus.o_IF_flush !== 1'b1) begin failures++; $display("FAIL shalt_drain_flush got=%b exp=1", bus.o_IF_flush); end
    endtask
`ifdef PIPE_CTRL_BREAKPOINT_EN
    task automatic test_breakpoint;
        logic adv;
        logic hit;
        do_reset;
        bus.i_bp_set = 1'b1;
        bus.i_bp_addr = 9'h010;
        @(negedge clk);
        bus.i_bp_set = 1'b0;
        cmd(2'b01);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            #1;
            if (bus.o_bp_hit === 1'b1) begin
                hit = 1'b1;
                checks++; if (bus.i_PC !== 9'h010) begin failures++; $display("FAIL bp_pc got=%h exp=010", bus.i_PC); end
                checks++; if (bus.o_PCwrite !== 1'b0) begin failures++; $display("FAIL bp_pcw got=%b exp=0", bus.o_PCwrite); end
            end
            adv = bus.o_PCwrite;
            @(negedge clk);
            if (adv) bus.i_PC = bus.i_PC + 9'd1;
        end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", hit); end
        #1;
        checks++; if (bus.o_pipe_enable !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b exp=0", bus.o_pipe_enable); end
        checks++; if (bus.o_bp_hit !== 1'b0) begin failures++; $display("FAIL bp_pulse got=%b exp=0", bus.o_bp_hit); end
        cmd(2'b01);
        #1;
        checks++; if (bus.o_PCwrite !== 1'b1) begin failures++; $display("FAIL bp_resume_pcw got=%b exp=1", bus.o_PCwrite); end
        checks++; if (bus.o_bp_hit !== 1'b0) begin failures++; $display("FAIL bp_resume_hit got=%b exp=0", bus.o_bp_hit); end
    endtask
`endif
    initial begin
        test_reset;
        test_run;
        test_step;
        test_stall_branch;
        test_halt;
        test_reset_drain;
        test_step_corner;
`ifdef PIPE_CTRL_BREAKPOINT_EN
        test_breakpoint;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
